irq_pending_latch: RTL

//  Upstream stage of the registered 8:3 priority encoder (pe). Captures raw

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_edge_det.sv | 28 ++
 rtl/irq_pending_latch.sv | 85 ++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending latch.
package irq_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    REQ     = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;
endpackage

// File: rtl/irq_edge_det.sv
// Request capture front end: rising-edge detect or level pass-through per line.
module irq_edge_det #(
  parameter int N    = 8,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq_in,
  output logic [N-1:0] set_vec
);

  generate
    if (EDGE) begin : g_edge
      logic [N-1:0] prev;

      // History resets to ones so lines already high at reset release do not fire.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= '1;
        else      prev <= irq_in;
      end

      assign set_vec = irq_in & ~prev;
    end else begin : g_level
      assign set_vec = irq_in;
    end
  endgenerate

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending/mask stage and CPU request/ack/EOI handshake ahead of the priority encoder.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int N     = irq_pkg::N,
  parameter int IDX_W = $clog2(N),
  parameter bit EDGE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     irq_in,
  input  logic [N-1:0]     irq_mask,
  output logic [N-1:0]     pend_vec,
  output logic             irq_valid,
  input  logic             irq_ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             eoi,
  output logic             busy,
  output logic [IDX_W-1:0] isr_idx
);

  irq_state_t   state, state_nxt;
  logic [N-1:0] pending;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic         ack_ok;

  irq_edge_det #(.N(N), .EDGE(EDGE)) u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .set_vec (set_vec)
  );

  // An ack only counts if the index it names is actually offered right now.
  assign ack_ok = (state == REQ) && irq_ack && pend_vec[ack_idx];

  always_comb begin
    clr_vec          = '0;
    clr_vec[ack_idx] = ack_ok;
  end

  // Set is OR-ed after the clear so a simultaneous set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      pend_vec <= '0;
      isr_idx  <= '0;
    end else begin
      pending  <= (pending & ~clr_vec) | set_vec;
      pend_vec <= pending & ~irq_mask;
      if (ack_ok) isr_idx <= ack_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend_vec) state_nxt = WAIT;
      WAIT:    state_nxt = (|pend_vec) ? REQ : IDLE;
      REQ: begin
        if (ack_ok)          state_nxt = SERVICE;
        else if (~|pend_vec) state_nxt = IDLE;
      end
      SERVICE: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      REQ:     irq_valid = 1'b1;
      SERVICE: busy      = 1'b1;
      default: ;
    endcase
  end

endmodule
